// File: rtl/hack_button_led_io.sv
// Hack memory-mapped button/LED peripheral: synchronises and debounces
// the board button, counts presses, and holds an LED register.
// Ports:
//   clk_in, reset_n      clock and async active-low reset
//   btn                  raw button, 0 = pressed
//   address/data_in/write CPU addressM/outM/writeM
//   data_out, sel_o      combinational read data and address-hit flag
//   led                  LED drive, 1 = on
// Map: +0 STATUS {sticky, pressed}, +1 PRESSCNT, +2 LEDREG.
`timescale 1ns/1ps
module hack_button_led_io #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [14:0] BASE_ADDR       = 15'h6000
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        btn,
    input  logic [14:0] address,
    input  logic [15:0] data_in,
    input  logic        write,
    output logic [15:0] data_out,
    output logic        sel_o,
    output logic        led
);

    localparam logic [23:0] TERM = 24'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE_REL = 1'b0,
        STABLE_PRS = 1'b1
    } state_t;

    logic        r_sync1;
    logic        r_sync2;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic        w_differ;
    logic        w_press_evt;
    logic        w_pressed;
    logic        r_sticky;
    logic [15:0] r_presscnt;
    logic [15:0] w_presscnt_base;
    logic        r_led;
    logic [14:0] w_off;
    logic        w_wr_stat;
    logic        w_wr_cnt;
    logic        w_wr_led;
    logic        w_unused;

    // Decode in 16 bits so a BASE_ADDR near the top cannot wrap.
    assign sel_o = ({1'b0, address} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, address} <= ({1'b0, BASE_ADDR} + 16'd2));
    assign w_off = address - BASE_ADDR;

    assign w_wr_stat = write && sel_o && (w_off == 15'd0);
    assign w_wr_cnt  = write && sel_o && (w_off == 15'd1);
    assign w_wr_led  = write && sel_o && (w_off == 15'd2);

    assign w_unused = ^data_in[15:1];

    // Plain two-flop synchroniser, idle level is released (1).
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: state register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= STABLE_REL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Debounce FSM: next state. Debounced level is 1 when released,
    // so btn_s differs when it disagrees with that level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_differ    = (r_sync2 != (r_state == STABLE_REL));
        if (w_differ) begin
            if (r_cnt == TERM) begin
                unique case (r_state)
                    STABLE_REL: w_state_nxt = STABLE_PRS;
                    STABLE_PRS: w_state_nxt = STABLE_REL;
                endcase
            end else begin
                w_cnt_nxt = r_cnt + 24'd1;
            end
        end
    end

    // Debounce FSM: outputs.
    always_comb begin
        w_pressed   = (r_state == STABLE_PRS);
        w_press_evt = (r_state == STABLE_REL) &&
                      (w_state_nxt == STABLE_PRS);
    end

    // A write clears first, then a coincident press counts on top.
    assign w_presscnt_base = w_wr_cnt ? 16'd0 : r_presscnt;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky   <= 1'b0;
            r_presscnt <= '0;
            r_led      <= 1'b0;
        end else begin
            if (w_press_evt) begin
                r_sticky <= 1'b1;
            end else if (w_wr_stat) begin
                r_sticky <= 1'b0;
            end
            r_presscnt <= w_presscnt_base + {15'd0, w_press_evt};
            if (w_wr_led) begin
                r_led <= data_in[0];
            end
        end
    end

    assign led = r_led;

    always_comb begin
        data_out = '0;
        if (sel_o) begin
            unique case (w_off)
                15'd0:   data_out = {14'd0, r_sticky, w_pressed};
                15'd1:   data_out = r_presscnt;
                15'd2:   data_out = {15'd0, r_led};
                default: data_out = '0;
            endcase
        end
    end

endmodule

// File: doc/hack_button_led_io.md
Name: hack_button_led_io

Overview:
- Memory-mapped I/O peripheral on the Hack data bus, sitting directly downstream of the CPU's addressM/outM/writeM outputs, next to data RAM.
- Synchronises and debounces the raw board button and counts presses.
- Exposes status, a press counter and an LED register at fixed addresses.
- Read data is muxed into the CPU's inM path by the top-level memory decoder whenever sel_o is high.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk_in cycles the synchronised button level must stay stable before the debounced state changes (10 ms at 100 MHz); legal range 2..2^24-1.
- BASE_ADDR, 15'h6000, first of the three peripheral word addresses.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- btn  input  1  raw board button, asynchronous to clk_in; 0 = pressed, 1 = released.
- address  input  15  CPU addressM.
- data_in  input  16  CPU outM.
- write  input  1  CPU writeM.
- data_out  output  16  read data for the decoded address.
- sel_o  output  1  high when address is in BASE_ADDR..BASE_ADDR+2.
- led  output  1  board LED; 1 = on.

Behaviour:
- Reset: while reset_n = 0, asynchronously clear all registers.
  - Sync flops reset to 1 (released).
  - Debounce counter = 0, debounced state = released.
  - Sticky = 0, press count = 0, LED register = 0.
  - Outputs: led = 0; data_out = 0 unless a decoded read of a register that is itself 0. sel_o is combinational on address.
- Synchroniser: two-flop chain on btn produces btn_s. No logic may be placed between the two flops.
- Debounce FSM, states STABLE_REL and STABLE_PRS:
  - Counter clears on any cycle where btn_s equals the current debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and btn_s still differs, the state flips on the next edge and the counter clears.
  - A bounce (btn_s returning to the debounced level) before the terminal count clears the counter with no state change.
- Press event: a one-cycle pulse on the STABLE_REL -> STABLE_PRS transition only. Release generates no event.
- Register map (word offsets from BASE_ADDR):
  - +0 STATUS, read-only. bit0 = debounced pressed, bit1 = sticky press flag, other bits 0. Any write clears sticky.
  - +1 PRESSCNT. 16-bit count of press events, wraps 16'hFFFF -> 0. Any write clears it to 0.
  - +2 LEDREG. bit0 drives led. Writes load data_in[0]; reads return {15'b0, led}.
- Read path: data_out is combinational from registers, with zero added latency, matching Hack Memory read timing. data_out = 0 when sel_o = 0.
- Write path: takes effect on the rising clk_in edge when write = 1 and address decodes. Writes to any other address are ignored.
- Simultaneous events on one edge:
  - Press event + write to STATUS: sticky ends at 1 (event wins).
  - Press event + write to PRESSCNT: counter ends at 1. The write clears, then the event counts.
  - Press event with PRESSCNT = 16'hFFFF: counter wraps to 0.
- Reset mid-debounce discards the partial count. After release of reset, a held button needs a full DEBOUNCE_CYCLES of stable low before the press registers.
- led follows LEDREG bit0 with no other gating.

Test Plan:
- Reset/idle: with DEBOUNCE_CYCLES = 8, hold reset_n = 0 with btn = 0. Then: led = 0; read +0 returns 0; read +1 returns 0; sel_o = 1 for 15'h6000..15'h6002; sel_o = 0 at 15'h6003 and 15'h5FFF.
- Clean press: btn 1 -> 0 held 20 cycles. STATUS reads 3 exactly 2 (sync) + 8 cycles after the btn edge; PRESSCNT = 1. Release btn -> STATUS = 2 after 10 cycles; PRESSCNT stays 1.
- Bounce rejection: btn toggles every 3 cycles for 40 cycles, then stays 1. STATUS bit0 never sets; PRESSCNT = 0.
- Counter wrap and clear-collision:
  - Preload via 65535 presses (or force), then press once -> PRESSCNT = 0.
  - Write 16'h1234 to +1 on the same edge as a press event -> PRESSCNT = 1.
- LED register: write 16'hFFFF to 15'h6002 -> led = 1 and read returns 16'h0001. Write 16'h0002 -> led = 0. Write to 15'h6003 -> no change.
- Async reset mid-operation: assert reset_n low asynchronously 5 counts into a debounce, with btn held 0. All state clears and led = 0 immediately. After deassert, STATUS bit0 sets 10 cycles later, not sooner.
